// File: rtl/main_fsm_if.sv
// Control bundle between the main FSM and the datapath / ALU decoder.
// master = controller side, slave = datapath side.
interface main_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       ir_write;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       next_pc;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       alu_op;
  logic       undef;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  op, funct, mem_ready,
    output ir_write, adr_src, alu_src_a, alu_src_b, result_src, next_pc,
           reg_w, mem_w, branch, alu_op, undef, mem_err, state
  );

  modport slave (
    output op, funct, mem_ready,
    input  ir_write, adr_src, alu_src_a, alu_src_b, result_src, next_pc,
           reg_w, mem_w, branch, alu_op, undef, mem_err, state
  );
endinterface

// File: rtl/main_fsm.sv
// Multicycle ARM main controller: FETCH/DECODE/EXECUTE/WRITEBACK sequencing
// with a memory-wait timeout that aborts back to FETCH.
module main_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  main_fsm_if.master bus
);

  localparam int unsigned CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic       wait_st, timeout;
  logic       ir_write_c, next_pc_c, reg_w_c, mem_w_c, undef_c, mem_err_c;
  logic       adr_src_c, alu_src_a_c, branch_c, alu_op_c;
  logic [1:0] alu_src_b_c, result_src_c;
  logic       unused_funct;

  assign unused_funct = ^bus.funct[4:1];

  assign wait_st = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign timeout = (MEM_TIMEOUT != 0) && wait_st && (wait_cnt_q == CNT_MAX) && !bus.mem_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_write_c   = 1'b0;
    next_pc_c    = 1'b0;
    reg_w_c      = 1'b0;
    mem_w_c      = 1'b0;
    undef_c      = 1'b0;
    mem_err_c    = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = 1'b0;
    branch_c     = 1'b0;
    alu_op_c     = 1'b0;
    alu_src_b_c  = 2'b00;
    result_src_c = 2'b00;

    case (state_q)
      FETCH: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = bus.mem_ready;
        next_pc_c    = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        case (bus.op)
          2'b00:   state_d = bus.funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   state_d = MEMADR;
          2'b10:   state_d = BRANCH;
          default: begin
            state_d = FETCH;
            undef_c = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_b_c = 2'b01;
        state_d     = bus.funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        result_src_c = 2'b01;
        reg_w_c      = 1'b1;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        adr_src_c = 1'b1;
        mem_w_c   = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXECUTER: begin
        alu_op_c = 1'b1;
        state_d  = ALUWB;
      end
      EXECUTEI: begin
        alu_src_b_c = 2'b01;
        alu_op_c    = 1'b1;
        state_d     = ALUWB;
      end
      ALUWB: begin
        reg_w_c = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        branch_c     = 1'b1;
        state_d      = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Abort overrides only the next state; per-state enables keep their values this cycle.
    if (timeout) begin
      mem_err_c = 1'b1;
      state_d   = FETCH;
    end
  end

  // FETCH->FETCH on timeout is not a state change, so it needs its own clear.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_d != state_q) || timeout) begin
      wait_cnt_d = '0;
    end else if (wait_st && !bus.mem_ready && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign bus.ir_write   = ir_write_c & reset_n;
  assign bus.next_pc    = next_pc_c  & reset_n;
  assign bus.reg_w      = reg_w_c    & reset_n;
  assign bus.mem_w      = mem_w_c    & reset_n;
  assign bus.undef      = undef_c    & reset_n;
  assign bus.mem_err    = mem_err_c  & reset_n;
  assign bus.adr_src    = adr_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.result_src = result_src_c;
  assign bus.branch     = branch_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.state      = state_q;

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle main controller FSM for the ARM core; sits directly upstream of the ALU decoder.
- Sequences FETCH/DECODE/EXECUTE/WRITEBACK per instruction and generates the datapath mux selects and raw write enables.
- Drives alu_op and branch into the ALU decoder.
- reg_w, mem_w, next_pc and branch are unconditioned; the downstream condition logic gates them.

Parameters:
MEM_TIMEOUT, 15, max cycles spent waiting on mem_ready in any wait state before abort; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
op  input  2  instr[27:26]: 00 data-proc, 01 memory, 10 branch, 11 undefined
funct  input  6  instr[25:20]; bit5 = I (immediate), bit0 = L (load)
mem_ready  input  1  memory completes current access this cycle
ir_write  output  1  load instruction register
adr_src  output  1  0 = PC, 1 = ALU result to memory address
alu_src_a  output  1  0 = Rn, 1 = PC
alu_src_b  output  2  00 = reg, 01 = ext imm, 10 = constant 4
result_src  output  2  00 = ALU out reg, 01 = mem data, 10 = ALU result
next_pc  output  1  PC write enable
reg_w  output  1  raw register-file write
mem_w  output  1  raw memory write
branch  output  1  raw branch (to ALU decoder and PC logic)
alu_op  output  1  1 = data-processing ALU decode
undef  output  1  1-cycle pulse on undefined op
mem_err  output  1  1-cycle pulse on memory timeout
state  output  4  current state encoding (debug)

Behaviour:
State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. Codes 10-15 are unreachable; if entered, next state is FETCH and all outputs are 0.

Reset:
- reset_n low asynchronously sets state = FETCH and wait_cnt = 0.
- While reset_n is low, ir_write, next_pc, reg_w, mem_w, undef and mem_err are forced to 0.

Outputs (Moore on state; mem_ready/op gating only where listed). Any signal not listed for a state is 0.
- FETCH: adr_src 0, alu_src_a 1, alu_src_b 10, result_src 10, ir_write = next_pc = mem_ready. Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_a 1, alu_src_b 10, result_src 10. Next state by op:
  - 01 -> MEMADR
  - 00 with funct[5] = 0 -> EXECUTER
  - 00 with funct[5] = 1 -> EXECUTEI
  - 10 -> BRANCH
  - 11 -> FETCH, with undef = 1 this cycle
- MEMADR: alu_src_a 0, alu_src_b 01. Next is MEMREAD if funct[0] = 1, else MEMWRITE.
- MEMREAD: adr_src 1. Go to MEMWB when mem_ready.
- MEMWB: result_src 01, reg_w 1. Next is FETCH.
- MEMWRITE: adr_src 1, mem_w 1 (held for the whole wait). Go to FETCH when mem_ready.
- EXECUTER: alu_src_a 0, alu_src_b 00, alu_op 1. Next is ALUWB.
- EXECUTEI: alu_src_a 0, alu_src_b 01, alu_op 1. Next is ALUWB.
- ALUWB: result_src 00, reg_w 1. Next is FETCH.
- BRANCH: alu_src_a 0, alu_src_b 01, result_src 10, branch 1. Next is FETCH.

Wait counter (wait states are FETCH, MEMREAD, MEMWRITE):
- wait_cnt is ceil(log2(MEM_TIMEOUT+1)) bits wide.
- It clears on every state change, and on re-entry to FETCH after a timeout.
- It increments each wait-state cycle with mem_ready = 0 and saturates at MEM_TIMEOUT.
- Timeout condition: MEM_TIMEOUT != 0, wait_cnt == MEM_TIMEOUT and mem_ready = 0. On that cycle:
  - mem_err = 1;
  - next state is FETCH;
  - ir_write, next_pc and mem_w still follow their normal per-state values that cycle.
- If mem_ready = 1 on the timeout cycle, mem_ready wins: normal transition, no mem_err.

Latency with zero wait states: data-proc 4 cycles, LDR 5, STR 4, B 3, undefined 2.

Inputs op and funct are sampled only in DECODE and MEMADR; their values in other states are don't-care.

Test Plan:
- Reset: hold reset_n = 0 with mem_ready = 1 -> state = 0; ir_write, next_pc, reg_w, mem_w all 0. Release reset_n -> next cycle ir_write = 1, next_pc = 1.
- ADD register, op = 00, funct = 001000, mem_ready = 1 -> states 0,1,6,8,0. alu_op = 1 only in state 6; reg_w = 1 only in state 8 with result_src = 00.
- LDR, op = 01, funct = 011001, mem_ready low for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0. reg_w = 1 in state 4 with result_src = 01; no mem_err.
- STR with mem_ready stuck at 0, MEM_TIMEOUT = 15 -> mem_w = 1 for 16 cycles in state 5; mem_err pulses once on the 16th; next state = 0. Repeat with mem_ready = 1 on that 16th cycle -> no mem_err.
- B, op = 10 -> states 0,1,9,0 with branch = 1, alu_src_b = 01 in state 9. Undefined op = 11 -> undef pulse in state 1, then state 0.
- Reset mid-op: assert reset_n low during state 5 with mem_w = 1 -> mem_w drops to 0 asynchronously and state = 0 without waiting for a clock edge. No mem_err after release.
